// File: rtl/fp_sqrt_arbiter_pkg.sv
// Shared types for the FP32 sqrt arbiter: latency constant,
// requester tag and tag-pipeline stage.
package fp_sqrt_arb_pkg;

  localparam int FP_SQRT_LATENCY = 28;

  // Tag sized for the largest supported requester count (16)
  localparam int MAX_REQ = 16;
  localparam int TAG_W   = $clog2(MAX_REQ);

  typedef logic [TAG_W-1:0] tag_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } stage_t;

  function automatic tag_t wrap_inc(
    input tag_t idx,
    input int   n
  );
    if (int'(idx) + 1 >= n)
      return '0;
    return tag_t'(int'(idx) + 1);
  endfunction

endpackage

// File: rtl/fp_sqrt_arbiter_if.sv
// Requester and sqrt-unit signal bundle.
// The slave modport faces the arbiter.
interface fp_sqrt_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [WIDTH-1:0]         resp_data;
  logic                     sqrt_go;
  logic [WIDTH-1:0]         sqrt_a;
  logic                     sqrt_done;
  logic [WIDTH-1:0]         sqrt_result;
  logic                     err_sticky;

  modport slave (
    input  req_valid,
    input  req_data,
    input  sqrt_done,
    input  sqrt_result,
    output req_ready,
    output resp_valid,
    output resp_data,
    output sqrt_go,
    output sqrt_a,
    output err_sticky
  );

  modport master (
    output req_valid,
    output req_data,
    output sqrt_done,
    output sqrt_result,
    input  req_ready,
    input  resp_valid,
    input  resp_data,
    input  sqrt_go,
    input  sqrt_a,
    input  err_sticky
  );

endinterface

// File: rtl/fp_sqrt_arbiter_rr.sv
// Combinational round-robin picker: searches upward from the
// pointer, returns one-hot grant, index and the next pointer.
module rr_arbiter
  import fp_sqrt_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  input  tag_t         i_ptr,
  output logic [N-1:0] o_gnt,
  output tag_t         o_idx,
  output logic         o_any,
  output tag_t         o_ptr_nxt
);

  int w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = 0;
    for (int k = 0; k < N; k++) begin
      w_j = (int'(i_ptr) + k) % N;
      if (!o_any && i_req[w_j]) begin
        o_any      = 1'b1;
        o_idx      = tag_t'(w_j);
        o_gnt[w_j] = 1'b1;
      end
    end
  end

  assign o_ptr_nxt = o_any ? wrap_inc(o_idx, N) : i_ptr;

endmodule

// File: rtl/fp_sqrt_arbiter.sv
// Shares one pipelined FP32 sqrt unit among NUM_REQ requesters.
// FP_SQRT_ARB_STATS_EN adds per-requester issue counters.
module fp_sqrt_arbiter
  import fp_sqrt_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = FP_SQRT_LATENCY,
  parameter int WIDTH   = 32
) (
  input  logic clock,
  input  logic reset_n,
  fp_sqrt_arbiter_if.slave bus
`ifdef FP_SQRT_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0] stat_issued
`endif
);

  localparam int BW = $clog2(LATENCY + 1);

  tag_t               r_ptr;
  tag_t               w_ptr_nxt;
  tag_t               w_idx;
  logic               w_any;
  logic [NUM_REQ-1:0] w_gnt;
  logic [WIDTH-1:0]   w_op;

  logic               r_go;
  tag_t               r_tag;
  logic [WIDTH-1:0]   r_a;
  stage_t             r_pipe [LATENCY];
  logic [BW-1:0]      r_blank;
  logic               r_err;
  logic               w_live;
  logic               w_hit;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .i_req     (bus.req_valid),
    .i_ptr     (r_ptr),
    .o_gnt     (w_gnt),
    .o_idx     (w_idx),
    .o_any     (w_any),
    .o_ptr_nxt (w_ptr_nxt)
  );

  assign bus.req_ready = reset_n ? w_gnt : '0;
  assign w_op = bus.req_data[int'(w_idx)*WIDTH +: WIDTH];

  // The issue register heads the tag pipe, so stage 0 lines
  // up with a done LATENCY cycles after sqrt_go.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_ptr   <= '0;
      r_go    <= 1'b0;
      r_tag   <= '0;
      r_a     <= '0;
      r_blank <= BW'(LATENCY);
      r_err   <= 1'b0;
      for (int i = 0; i < LATENCY; i++)
        r_pipe[i] <= '0;
    end else begin
      r_ptr <= w_ptr_nxt;
      r_go  <= w_any;
      r_tag <= w_idx;
      if (w_any)
        r_a <= w_op;
      r_pipe[LATENCY-1] <= '{valid: r_go, tag: r_tag};
      for (int i = 0; i < LATENCY - 1; i++)
        r_pipe[i] <= r_pipe[i+1];
      if (r_blank != '0)
        r_blank <= r_blank - 1'b1;
      if (w_live && (r_pipe[0].valid != bus.sqrt_done))
        r_err <= 1'b1;
    end
  end

  // Done line is untrustworthy until the unit's shift chain flushes
  assign w_live = reset_n && (r_blank == '0);
  assign w_hit  = w_live && r_pipe[0].valid && bus.sqrt_done;

  always_comb begin
    bus.resp_valid = '0;
    if (w_hit)
      bus.resp_valid[int'(r_pipe[0].tag)] = 1'b1;
  end

  assign bus.resp_data  = bus.sqrt_result;
  assign bus.sqrt_go    = r_go;
  assign bus.sqrt_a     = r_a;
  assign bus.err_sticky = r_err;

`ifdef FP_SQRT_ARB_STATS_EN
  logic [31:0] r_cnt [NUM_REQ];

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++)
        r_cnt[i] <= '0;
    end else if (w_any) begin
      r_cnt[int'(w_idx)] <= r_cnt[int'(w_idx)] + 32'd1;
    end
  end

  always_comb begin
    stat_issued = '0;
    for (int i = 0; i < NUM_REQ; i++)
      stat_issued[i*32 +: 32] = r_cnt[i];
  end
`else
  // No statistics in this build.
`endif

endmodule

// File: tb/tb_fp_sqrt_arbiter.sv
// Directed + random bench for fp_sqrt_arbiter with a 28-deep
// sqrt unit model and a cycle-indexed expectation scoreboard.
module tb_fp_sqrt_arbiter;
  import fp_sqrt_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 28;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  always #5 clock = ~clock;

  fp_sqrt_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus();

`ifdef FP_SQRT_ARB_STATS_EN
  logic [N*32-1:0] stat_issued;
`endif

  fp_sqrt_arbiter #(.NUM_REQ(N), .LATENCY(L), .WIDTH(W)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FP_SQRT_ARB_STATS_EN
    ,
    .stat_issued (stat_issued)
`endif
  );

  function automatic logic [31:0] fsqrt(input logic [31:0] a);
    logic [63:0] d;
    logic [63:0] r;
    real x;
    if (a[30:23] == 8'd0)
      return 32'd0;
    d = {1'b0, 11'(a[30:23]) + 11'd896, a[22:0], 29'd0};
    x = $sqrt($bitstoreal(d));
    r = $realtobits(x);
    return {1'b0, 8'(r[62:52] - 11'd896), r[51:29]};
  endfunction

  logic [L-1:0] go_sr;
  logic [W-1:0] res_sr [L];
  logic rand_on  = 1'b0;
  logic rand_bit = 1'b0;
  logic drop     = 1'b0;

  always @(posedge clock) begin
    go_sr     <= {go_sr[L-2:0], bus.sqrt_go};
    res_sr[0] <= fsqrt(bus.sqrt_a);
    for (int i = 1; i < L; i++)
      res_sr[i] <= res_sr[i-1];
  end

  assign bus.sqrt_done   = rand_on ? rand_bit : (go_sr[L-1] & ~drop);
  assign bus.sqrt_result = res_sr[L-1];

  int          cyc;
  int          ptr;
  int          passed;
  int          fails;
  int          total;
  logic        e_err;
  logic [3:0]  e_rv [64];
  logic [31:0] e_rd [64];
  logic        e_go [64];
  logic [31:0] e_a  [64];
  int          cnt  [N];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pick(input logic [3:0] v, input int p);
    int j;
    for (int k = 0; k < N; k++) begin
      j = (p + k) % N;
      if (v[j])
        return 4'(1 << j);
    end
    return 4'd0;
  endfunction

  function automatic logic [31:0] rand_op();
    return {1'b0, 8'($urandom_range(1, 254)), 23'($urandom)};
  endfunction

  task automatic drive(input logic [3:0] v);
    bus.req_valid = v;
    for (int i = 0; i < N; i++)
      bus.req_data[i*32 +: 32] = rand_op();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 64; i++) begin
      e_rv[i] = '0;
      e_rd[i] = '0;
      e_go[i] = 1'b0;
      e_a[i]  = '0;
    end
    for (int i = 0; i < N; i++)
      cnt[i] = 0;
    ptr   = 0;
    e_err = 1'b0;
  endtask

  task automatic tick();
    int s;
    int gi;
    int so;
    logic [3:0]  g;
    logic [31:0] d;
    #1;
    s = cyc & 63;
    if (!reset_n || drop)
      e_rv[s] = '0;
    g = reset_n ? pick(bus.req_valid, ptr) : 4'd0;
    chk("req_ready", 32'(bus.req_ready), 32'(g));
    chk("resp_valid", 32'(bus.resp_valid), 32'(e_rv[s]));
    if (e_rv[s] != 4'd0)
      chk("resp_data", bus.resp_data, e_rd[s]);
    chk("sqrt_go", 32'(bus.sqrt_go), 32'(e_go[s]));
    if (e_go[s])
      chk("sqrt_a", bus.sqrt_a, e_a[s]);
    chk("err_sticky", 32'(bus.err_sticky), 32'(e_err));
    e_rv[s] = '0;
    e_go[s] = 1'b0;
    if (drop)
      e_err = 1'b1;
    if (!reset_n) begin
      clear_model();
    end else if (g != 4'd0) begin
      gi = 0;
      for (int i = 0; i < N; i++)
        if (g[i]) gi = i;
      d  = bus.req_data[gi*32 +: 32];
      so = (cyc + L + 1) & 63;
      e_go[(cyc + 1) & 63] = 1'b1;
      e_a[(cyc + 1) & 63]  = d;
      e_rv[so] = g;
      e_rd[so] = fsqrt(d);
      ptr = (gi + 1) % N;
      cnt[gi]++;
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  initial begin
    int n;
    passed = 0;
    fails  = 0;
    total  = 0;
    cyc    = 0;
    clear_model();
    bus.req_valid = '0;
    bus.req_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    drive(4'hF);
    tick();

    reset_n = 1'b1;
    drive(4'h0);
    rand_on = 1'b1;
    repeat (L) begin
      rand_bit = 1'($urandom);
      tick();
    end
    rand_on = 1'b0;

    bus.req_valid = 4'b0100;
    bus.req_data[2*32 +: 32] = 32'h4080_0000;
    tick();
    drive(4'h0);
    repeat (32) tick();

    repeat (8) begin
      drive(4'hF);
      tick();
    end
    drive(4'h0);
    repeat (32) tick();

    repeat (60) begin
      drive(4'($urandom));
      tick();
    end
    drive(4'h0);
    repeat (32) tick();

    n = cyc;
    drive(4'b0001);
    tick();
    drive(4'h0);
    while (cyc < n + L + 1)
      tick();
    drop = 1'b1;
    tick();
    drop = 1'b0;
    repeat (6) tick();

    repeat (10) begin
      drive(4'($urandom_range(1, 15)));
      tick();
    end
    reset_n = 1'b0;
    drive(4'hF);
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (12) begin
      drive(4'($urandom));
      tick();
    end
    drive(4'h0);
    repeat (34) tick();

    reset_n = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (5) begin
      drive(4'b0010);
      tick();
    end
    repeat (3) begin
      drive(4'b1000);
      tick();
    end
    drive(4'h0);
    repeat (32) tick();

`ifdef FP_SQRT_ARB_STATS_EN
    for (int i = 0; i < N; i++)
      chk($sformatf("stat_issued[%0d]", i),
          stat_issued[i*32 +: 32], 32'(cnt[i]));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
